capture_packer: RTL and testbench
=================================

Name: capture_packer

Overview:
- Parametrised byte-to-word packer between the USB capture stream (8-bit valid/ack) and the wide host FIFO write side.
- Generalises the fixed two-byte pairing to LANES bytes per word.
- Adds explicit flush with partial-word byte count and zero-length markers, idle-timeout auto-flush, and a built-in xorshift16 test-pattern mode.
- Sits in the capture clock domain, directly ahead of the clock-crossing FIFO.

Parameters:
- LANES, 2, bytes per output word; allowed range 1..8; output width is LANES*8.
- TIMEOUT, 1024, idle cycles with a partial word held before auto-flush; 0 disables auto-flush.
- PAD, 8'h00, fill value for unused lanes of a partial word.

Ports:
- clk_i  in  1  capture clock.
- reset_i  in  1  asynchronous, active-high reset.
- in_data_i  in  8  capture byte.
- in_valid_i  in  1  byte available.
- in_ack_o  out  1  byte consumed this cycle (combinational).
- out_data_o  out  LANES*8  packed word; lane 0 (bits 7:0) holds the oldest byte.
- out_count_o  out  clog2(LANES+1)  number of valid lanes, 0..LANES.
- out_last_o  out  1  word ends a packet (flush, timeout, or zero-length marker).
- out_valid_o  out  1  word available.
- out_ready_i  in  1  sink accepts the word.
- flush_i  in  1  single-cycle flush request.
- test_i  in  1  test-pattern mode.
- idle_o  out  1  accumulator empty, output register empty, no flush pending.

Behaviour:
- Reset, asynchronous:
  - acc_cnt=0, out_valid_o=0, out_last_o=0, out_count_o=0, out_data_o=0, flush_pend=0, idle counter=0, rng=16'h6c41.
  - idle_o=1. in_ack_o=0 while reset_i is high.
- State: accumulator acc_r[LANES*8], acc_cnt (0..LANES), one output register, flush_pend, idle counter.
- slot_free = !out_valid_o || out_ready_i.
- Output handshake: transfer occurs when out_valid_o && out_ready_i. While out_valid_o=1 and out_ready_i=0, the output register and all out_* signals are held stable.
- Move (accumulator to output register) fires when slot_free and one of:
  - acc_cnt==LANES: count=LANES, last=0.
  - flush_pend: count=acc_cnt, lanes >= acc_cnt filled with PAD, last=1. acc_cnt=0 gives a zero-length marker (count 0, all lanes PAD, last=1).
  - Timeout hit with acc_cnt>0: same as flush, last=1.
- On a move, acc_cnt clears, flush_pend clears, and the idle counter clears.
- in_ack_o = in_valid_i && !test_i && !flush_pend && (acc_cnt<LANES || move fires this cycle).
- An acked byte is written to lane acc_cnt, or to lane 0 if a move fires in the same cycle. acc_cnt increments. This sustains one byte per clock with no bubble at word boundaries.
- flush_i while flush_pend is already set is ignored. flush_i in the same cycle as a full-word move: the full word moves first with last=0, and flush_pend stays set so the next move is the flush.
- Idle counter:
  - Counts while acc_cnt>0 and no byte is acked; any ack clears it.
  - Hit when it reaches TIMEOUT-1 (counter width clog2(TIMEOUT+1)); saturates until the move.
  - Does nothing when acc_cnt==0.
- Test mode (test_i=1):
  - Input is stalled, acc_cnt is forced to 0, flush_pend is cleared.
  - A word already in the output register completes its handshake first.
  - After that, out_valid_o=1 continuously with count=LANES, last=0.
  - out_data_o = current rng value replicated across 16-bit lanes and truncated to LANES*8.
  - rng advances by xorshift16 on each transfer: t1=s^(s<<7); t2=t1^(t1>>9); next=t2^(t2<<8), all 16-bit.
  - The first test word uses next(16'h6c41)=16'habe7.
  - test_i low reloads rng to next(16'h6c41).
- test_i falling while a test word is pending: that word completes normally, then packing resumes.

Decomposition:
- Package capture_pkg: xorshift16 next-state function, RNG_SEED=16'h6c41, count-width helper.
- One sub-module: capture_packer_rng (xorshift16 state register with advance and reload), reusable by the host-side test logic.

Test Plan:
- LANES=2, ready=1, bytes 11,22,33,44 back-to-back -> words 16'h2211, 16'h4433, count=2, last=0, in_ack_o high all 4 cycles.
- LANES=4, bytes AA,BB then flush_i -> one word 32'h0000BBAA, count=2, last=1; next flush_i with no bytes -> count=0, last=1.
- LANES=2, TIMEOUT=8, single byte 5A then idle -> word 16'h005A, count=1, last=1 exactly 8 cycles after the ack; no earlier word.
- Backpressure: ready=0 for 10 cycles during a stream -> at most LANES*2 bytes acked, then in_ack_o=0; output held stable; no loss or reorder after ready returns.
- test_i=1, LANES=2, ready=1 -> words abe7, then next(abe7)...; test_i=0 then 1 again -> restarts at abe7.
- reset_i asserted mid-word, asynchronous -> outputs cleared immediately; first word after release contains only post-reset bytes.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the capture packer: RNG seed, xorshift16 step
// and a helper that sizes counters able to hold 0..n.
package capture_pkg;

  localparam logic [15:0] RNG_SEED = 16'h6c41;

  // One xorshift16 step: t1 = s^(s<<7); t2 = t1^(t1>>9); next = t2^(t2<<8).
  function automatic logic [15:0] xorshift16(input logic [15:0] s);
    logic [15:0] t1;
    logic [15:0] t2;
    t1 = s ^ (s << 7);
    t2 = t1 ^ (t1 >> 9);
    return t2 ^ (t2 << 8);
  endfunction

  // Bits needed to count 0..n; never less than one bit.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/capture_packer_rng.sv
// xorshift16 test-pattern generator state. The state can be advanced by
// one step or reloaded to the first pattern word, next(RNG_SEED).
module capture_packer_rng
  import capture_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        reload,
  input  logic        advance,
  output logic [15:0] state,
  output logic [15:0] state_next
);

  logic [15:0] rng;

  assign state      = rng;
  assign state_next = xorshift16(rng);

  // Reload has priority so leaving test mode always restarts the sequence.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rng <= RNG_SEED;
    end else if (reload) begin
      rng <= xorshift16(RNG_SEED);
    end else if (advance) begin
      rng <= state_next;
    end
  end

endmodule

// File: rtl/capture_packer.sv
// Packs the 8-bit capture stream into LANES-byte words for the host FIFO.
// Supports explicit flush (partial word / zero-length marker), idle-timeout
// auto-flush and an xorshift16 test-pattern mode. Lane 0 holds the oldest byte.
module capture_packer
  import capture_pkg::*;
#(
  parameter int         LANES   = 2,
  parameter int         TIMEOUT = 1024,
  parameter logic [7:0] PAD     = 8'h00
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [7:0]                   in_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ack_o,
  output logic [LANES*8-1:0]           out_data_o,
  output logic [$clog2(LANES+1)-1:0]   out_count_o,
  output logic                         out_last_o,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  input  logic                         flush_i,
  input  logic                         test_i,
  output logic                         idle_o
);

  localparam int W  = LANES * 8;
  localparam int CW = count_width(LANES);
  localparam int IW = count_width(TIMEOUT);
  localparam logic [CW-1:0] FULL     = CW'(LANES);
  localparam logic [IW-1:0] IDLE_MAX = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  // accumulator and control state
  logic [CW-1:0] acc_cnt, acc_cnt_next;
  logic          flush_pend, pend_next;
  logic [IW-1:0] idle_cnt, idle_next;

  // output register
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
  logic          out_last;
  logic          out_valid;
  logic          out_test;

  // datapath helpers
  logic          slot_free, xfer, acc_full, acc_some, hit;
  logic          move, ack, test_load, rng_advance, rng_reload;
  logic [CW-1:0] wr_lane;
  logic [W-1:0]  move_data, test_data;
  logic [15:0]   rng_state, rng_next, load_rng;

  assign slot_free = !out_valid || out_ready_i;
  assign xfer      = out_valid && out_ready_i;
  assign acc_full  = (acc_cnt == FULL);
  assign acc_some  = (acc_cnt != '0);
  assign hit       = (TIMEOUT > 0) && acc_some && (idle_cnt == IDLE_MAX);

  // A full word always takes priority; flush and timeout then close a packet.
  assign move      = !test_i && slot_free && (acc_full || flush_pend || hit);
  assign ack       = !reset_i && in_valid_i && !test_i && !flush_pend && (!acc_full || move);
  assign wr_lane   = move ? '0 : acc_cnt;
  assign test_load = test_i && slot_free;

  // The held test word is consumed this cycle, so the replacement uses the next value.
  assign rng_advance = xfer && out_test;
  assign rng_reload  = !test_i;
  assign load_rng    = rng_advance ? rng_next : rng_state;

  capture_packer_rng u_rng (
    .clk        (clk_i),
    .reset      (reset_i),
    .reload     (rng_reload),
    .advance    (rng_advance),
    .state      (rng_state),
    .state_next (rng_next)
  );

  genvar gi;

  // One byte register per lane; lanes at or beyond acc_cnt read as PAD when moved.
  for (gi = 0; gi < LANES; gi++) begin : g_lane
    logic [7:0] lane;

    // capture the acked byte into this lane
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        lane <= '0;
      end else if (ack && (wr_lane == CW'(gi))) begin
        lane <= in_data_i;
      end
    end

    assign move_data[gi*8 +: 8] = (CW'(gi) < acc_cnt) ? lane : PAD;
  end

  // Test word: RNG value repeated every 16 bits, truncated to the word width.
  for (gi = 0; gi < W; gi++) begin : g_test
    assign test_data[gi] = load_rng[gi % 16];
  end

  // next-state for byte count, pending flush and idle counter
  always_comb begin
    acc_cnt_next = acc_cnt;
    pend_next    = flush_pend;
    idle_next    = idle_cnt;
    if (test_i) begin
      acc_cnt_next = '0;
      pend_next    = 1'b0;
      idle_next    = '0;
    end else begin
      if (ack) begin
        acc_cnt_next = move ? CW'(1) : acc_cnt + CW'(1);
      end else if (move) begin
        acc_cnt_next = '0;
      end
      // A flush coinciding with a flush/timeout move is absorbed by that move;
      // one coinciding with a full-word move stays pending for the next move.
      if (move && !acc_full) begin
        pend_next = 1'b0;
      end else if (flush_i) begin
        pend_next = 1'b1;
      end
      if (ack || move) begin
        idle_next = '0;
      end else if ((TIMEOUT > 0) && acc_some && (idle_cnt != IDLE_MAX)) begin
        idle_next = idle_cnt + IW'(1);
      end
    end
  end

  // control state registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_cnt    <= '0;
      flush_pend <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      acc_cnt    <= acc_cnt_next;
      flush_pend <= pend_next;
      idle_cnt   <= idle_next;
    end
  end

  // output register: load a test word or a moved word, else drop after transfer
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_data  <= '0;
      out_count <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      out_test  <= 1'b0;
    end else if (test_load) begin
      out_data  <= test_data;
      out_count <= FULL;
      out_last  <= 1'b0;
      out_valid <= 1'b1;
      out_test  <= 1'b1;
    end else if (move) begin
      out_data  <= move_data;
      out_count <= acc_cnt;
      out_last  <= !acc_full;
      out_valid <= 1'b1;
      out_test  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b0;
      out_test  <= 1'b0;
    end
  end

  assign in_ack_o    = ack;
  assign out_data_o  = out_data;
  assign out_count_o = out_count;
  assign out_last_o  = out_last;
  assign out_valid_o = out_valid;
  assign idle_o      = !acc_some && !out_valid && !flush_pend;

endmodule

// File: tb/tb_capture_packer.sv
// Directed bench for capture_packer: a LANES=2/TIMEOUT=8 instance and a
// LANES=4/no-timeout instance, driven from a vector table plus hand sequences.
module tb_capture_packer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LANES=2, TIMEOUT=8 instance
  logic        a_valid, a_ready, a_flush, a_test, a_ack, a_last, a_ov, a_idle;
  logic [7:0]  a_data;
  logic [15:0] a_odata;
  logic [1:0]  a_cnt;

  // LANES=4, TIMEOUT=0 instance
  logic        b_valid, b_ready, b_flush, b_test, b_ack, b_last, b_ov, b_idle;
  logic [7:0]  b_data;
  logic [31:0] b_odata;
  logic [2:0]  b_cnt;

  capture_packer #(.LANES(2), .TIMEOUT(8), .PAD(8'h00)) dut2 (
    .clk_i(clk), .reset_i(rst), .in_data_i(a_data), .in_valid_i(a_valid),
    .in_ack_o(a_ack), .out_data_o(a_odata), .out_count_o(a_cnt),
    .out_last_o(a_last), .out_valid_o(a_ov), .out_ready_i(a_ready),
    .flush_i(a_flush), .test_i(a_test), .idle_o(a_idle)
  );

  capture_packer #(.LANES(4), .TIMEOUT(0), .PAD(8'h00)) dut4 (
    .clk_i(clk), .reset_i(rst), .in_data_i(b_data), .in_valid_i(b_valid),
    .in_ack_o(b_ack), .out_data_o(b_odata), .out_count_o(b_cnt),
    .out_last_o(b_last), .out_valid_o(b_ov), .out_ready_i(b_ready),
    .flush_i(b_flush), .test_i(b_test), .idle_o(b_idle)
  );

  typedef struct {
    int          sel;
    logic        valid;
    logic [7:0]  data;
    logic        ready;
    logic        flush;
    logic        test;
    logic        e_ack;
    logic        e_v;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_last;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int sel, input logic v, input logic [7:0] d, input logic r,
                     input logic f, input logic t, input logic ea, input logic ev,
                     input logic [31:0] ed, input logic [2:0] ec, input logic el);
    vec_t x;
    x.sel = sel; x.valid = v; x.data = d; x.ready = r; x.flush = f; x.test = t;
    x.e_ack = ea; x.e_v = ev; x.e_data = ed; x.e_cnt = ec; x.e_last = el;
    vecs.push_back(x);
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_data = 8'h00; a_ready = 1'b1; a_flush = 1'b0; a_test = 1'b0;
    b_valid = 1'b0; b_data = 8'h00; b_ready = 1'b1; b_flush = 1'b0; b_test = 1'b0;
  endtask

  // Drive one row at posedge+1, compare at posedge+2, then step one clock.
  task automatic run_vec(input vec_t x, input int idx);
    logic        act_ack, act_v, act_last;
    logic [31:0] act_data;
    logic [2:0]  act_cnt;
    idle_inputs();
    if (x.sel == 0) begin
      a_valid = x.valid; a_data = x.data; a_ready = x.ready; a_flush = x.flush; a_test = x.test;
    end else begin
      b_valid = x.valid; b_data = x.data; b_ready = x.ready; b_flush = x.flush; b_test = x.test;
    end
    #1;
    if (x.sel == 0) begin
      act_ack = a_ack; act_v = a_ov; act_data = {16'h0, a_odata}; act_cnt = {1'b0, a_cnt}; act_last = a_last;
    end else begin
      act_ack = b_ack; act_v = b_ov; act_data = b_odata; act_cnt = b_cnt; act_last = b_last;
    end
    $display("vec%0d sel=%0d ack=%0b valid=%0b data=%h cnt=%0d last=%0b",
             idx, x.sel, act_ack, act_v, act_data, act_cnt, act_last);
    chk($sformatf("vec%0d ack", idx), 32'(act_ack), 32'(x.e_ack));
    chk($sformatf("vec%0d out_valid", idx), 32'(act_v), 32'(x.e_v));
    if (x.e_v) begin
      chk($sformatf("vec%0d data", idx), act_data, x.e_data);
      chk($sformatf("vec%0d count", idx), 32'(act_cnt), 32'(x.e_cnt));
      chk($sformatf("vec%0d last", idx), 32'(act_last), 32'(x.e_last));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // ---- vector table: sel, valid, data, ready, flush, test | ack, v, data, cnt, last
    // back-to-back stream on LANES=2
    add(0, 1, 8'h11, 1, 0, 0,  1, 0, 32'h0, 0, 0);
    add(0, 1, 8'h22, 1, 0, 0,  1, 0, 32'h0, 0, 0);
    add(0, 1, 8'h33, 1, 0, 0,  1, 0, 32'h0, 0, 0);
    add(0, 1, 8'h44, 1, 0, 0,  1, 1, 32'h2211, 2, 0);
    add(0, 0, 8'h00, 1, 0, 0,  0, 0, 32'h0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0,  0, 1, 32'h4433, 2, 0);
    add(0, 0, 8'h00, 1, 0, 0,  0, 0, 32'h0, 0, 0);
    // backpressure: ready low for 10 cycles
    add(0, 1, 8'h01, 0, 0, 0,  1, 0, 32'h0, 0, 0);
    add(0, 1, 8'h02, 0, 0, 0,  1, 0, 32'h0, 0, 0);
    add(0, 1, 8'h03, 0, 0, 0,  1, 0, 32'h0, 0, 0);
    add(0, 1, 8'h04, 0, 0, 0,  1, 1, 32'h0201, 2, 0);
    for (int i = 0; i < 6; i++) add(0, 1, 8'h05, 0, 0, 0,  0, 1, 32'h0201, 2, 0);
    add(0, 1, 8'h05, 1, 0, 0,  1, 1, 32'h0201, 2, 0);
    add(0, 1, 8'h06, 1, 0, 0,  1, 1, 32'h0403, 2, 0);
    add(0, 0, 8'h00, 1, 0, 0,  0, 0, 32'h0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0,  0, 1, 32'h0605, 2, 0);
    add(0, 0, 8'h00, 1, 0, 0,  0, 0, 32'h0, 0, 0);
    // test-pattern mode: abe7, 134b, 2690, stall, leave, re-enter restarts at abe7
    add(0, 1, 8'h77, 1, 0, 1,  0, 0, 32'h0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 1,  0, 1, 32'habe7, 2, 0);
    add(0, 0, 8'h00, 1, 0, 1,  0, 1, 32'h134b, 2, 0);
    add(0, 0, 8'h00, 0, 0, 1,  0, 1, 32'h2690, 2, 0);
    add(0, 0, 8'h00, 0, 0, 0,  0, 1, 32'h2690, 2, 0);
    add(0, 0, 8'h00, 1, 0, 0,  0, 1, 32'h2690, 2, 0);
    add(0, 0, 8'h00, 1, 0, 0,  0, 0, 32'h0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 1,  0, 0, 32'h0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0,  0, 1, 32'habe7, 2, 0);
    add(0, 0, 8'h00, 1, 0, 0,  0, 0, 32'h0, 0, 0);
    // LANES=4: partial flush, ack blocked while flush pending, zero-length marker
    add(1, 1, 8'hAA, 1, 0, 0,  1, 0, 32'h0, 0, 0);
    add(1, 1, 8'hBB, 1, 0, 0,  1, 0, 32'h0, 0, 0);
    add(1, 0, 8'h00, 1, 1, 0,  0, 0, 32'h0, 0, 0);
    add(1, 1, 8'hCC, 1, 0, 0,  0, 0, 32'h0, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0,  0, 1, 32'h0000BBAA, 2, 1);
    add(1, 0, 8'h00, 1, 1, 0,  0, 0, 32'h0, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0,  0, 0, 32'h0, 0, 0);
    add(1, 0, 8'h00, 1, 0, 0,  0, 1, 32'h00000000, 0, 1);
    add(1, 0, 8'h00, 1, 0, 0,  0, 0, 32'h0, 0, 0);

    // ---- reset state, checked mid-cycle while reset is held
    rst = 1'b1;
    idle_inputs();
    a_valid = 1'b1; a_data = 8'h99;
    #12;
    chk("reset ack", 32'(a_ack), 32'd0);
    chk("reset out_valid", 32'(a_ov), 32'd0);
    chk("reset idle", 32'(a_idle), 32'd1);
    chk("reset data", b_odata, 32'h0);
    chk("reset count", 32'(b_cnt), 32'd0);
    chk("reset last", 32'(b_last), 32'd0);
    idle_inputs();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-reset idle", 32'(a_idle), 32'd1);

    // ---- table
    foreach (vecs[i]) run_vec(vecs[i], i);

    // ---- idle timeout: one byte, word appears exactly 8 clocks after its ack
    idle_inputs();
    a_valid = 1'b1; a_data = 8'h5A;
    #1;
    chk("timeout ack", 32'(a_ack), 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    #1;
    chk("timeout idle_o busy", 32'(a_idle), 32'd0);
    n = 0;
    while (!a_ov && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    $display("timeout word after %0d clocks data=%h cnt=%0d last=%0b", n, a_odata, a_cnt, a_last);
    chk("timeout latency", 32'(n), 32'd8);
    chk("timeout data", {16'h0, a_odata}, 32'h005A);
    chk("timeout count", 32'(a_cnt), 32'd1);
    chk("timeout last", 32'(a_last), 32'd1);
    @(posedge clk); #1;
    chk("timeout drained", 32'(a_ov), 32'd0);
    chk("timeout idle_o", 32'(a_idle), 32'd1);

    // ---- asynchronous reset mid-word
    idle_inputs();
    a_ready = 1'b0; a_valid = 1'b1;
    a_data = 8'hE1; @(posedge clk); #1;
    a_data = 8'hE2; @(posedge clk); #1;
    a_data = 8'hE3; @(posedge clk); #1;
    chk("pre-reset word held", 32'(a_ov), 32'd1);
    a_data = 8'hF4;
    #2;
    rst = 1'b1;
    #1;
    $display("async reset asserted valid=%0b data=%h ack=%0b idle=%0b", a_ov, a_odata, a_ack, a_idle);
    chk("async reset out_valid", 32'(a_ov), 32'd0);
    chk("async reset data", {16'h0, a_odata}, 32'h0);
    chk("async reset count", 32'(a_cnt), 32'd0);
    chk("async reset ack", 32'(a_ack), 32'd0);
    chk("async reset idle", 32'(a_idle), 32'd1);
    idle_inputs();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    a_valid = 1'b1; a_data = 8'h5B;
    #1;
    chk("post-reset ack 0", 32'(a_ack), 32'd1);
    @(posedge clk); #1;
    a_data = 8'h6C;
    #1;
    chk("post-reset ack 1", 32'(a_ack), 32'd1);
    @(posedge clk); #1;
    a_valid = 1'b0;
    @(posedge clk); #1;
    $display("post-reset word valid=%0b data=%h cnt=%0d last=%0b", a_ov, a_odata, a_cnt, a_last);
    chk("post-reset out_valid", 32'(a_ov), 32'd1);
    chk("post-reset data", {16'h0, a_odata}, 32'h6C5B);
    chk("post-reset count", 32'(a_cnt), 32'd2);
    chk("post-reset last", 32'(a_last), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
